// File: rtl/bp_update_ctrl_cp4_pkg.sv
// Shared constants and FSM encoding for the branch-predictor update controller.
package bp_update_ctrl_cp4_pkg;

    localparam int BP_AWIDTH = 30;
    localparam int BP_DWIDTH = 2;
    localparam int BP_DEPTH  = 4;

    localparam logic [BP_DWIDTH-1:0] BP_CTR_MAX     = '1;
    localparam logic [BP_DWIDTH-1:0] BP_CTR_WEAK_T  = BP_DWIDTH'(1) << (BP_DWIDTH - 1);
    localparam logic [BP_DWIDTH-1:0] BP_CTR_WEAK_NT = BP_CTR_WEAK_T - 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2
    } bp_state_e;

endpackage

// File: rtl/bp_update_ctrl_cp4_if.sv
// Resolved-branch handshake from execute into the update controller.
interface bp_update_ctrl_cp4_if
    import bp_update_ctrl_cp4_pkg::*;
#(
    parameter int AWIDTH = BP_AWIDTH
);
    logic              valid;
    logic              ready;
    logic [AWIDTH-1:0] pc;
    logic              taken;

    modport master (output valid, output pc, output taken, input ready);
    modport slave  (input valid, input pc, input taken, output ready);
endinterface

// File: rtl/bp_update_ctrl_cp4_upd_fifo.sv
// Show-ahead synchronous FIFO holding {pc, taken} update entries.
module bp_update_ctrl_cp4_upd_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/bp_update_ctrl_cp4.sv
// Queues resolved branches and read-modify-writes their saturating counters
// through cache read port 1 and the cache write port.
//   state  | meaning
//   IDLE   | no update in progress, waiting for a queued entry
//   LOOKUP | head entry looked up on ra1, new counter computed, head popped
//   WRITE  | registered write of the new counter commits at the closing edge
module bp_update_ctrl_cp4
    import bp_update_ctrl_cp4_pkg::*;
#(
    parameter int AWIDTH = BP_AWIDTH,
    parameter int DWIDTH = BP_DWIDTH,
    parameter int DEPTH  = BP_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    bp_update_ctrl_cp4_if.slave        upd,
    output logic [AWIDTH-1:0]          cache_ra_o,
    input  logic [DWIDTH-1:0]          cache_dout_i,
    input  logic                       cache_hit_i,
    output logic [AWIDTH-1:0]          cache_wa_o,
    output logic [DWIDTH-1:0]          cache_din_o,
    output logic                       cache_we_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       idle_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [DWIDTH:0]   CTR_MAX     = {1'b0, {DWIDTH{1'b1}}};
    localparam logic [DWIDTH-1:0] CTR_WEAK_T  = DWIDTH'(1) << (DWIDTH - 1);
    localparam logic [DWIDTH-1:0] CTR_WEAK_NT = CTR_WEAK_T - 1'b1;

    bp_state_e         state_q, state_d;
    logic [AWIDTH-1:0] wa_q, wa_d;
    logic [DWIDTH-1:0] din_q, din_d;
    logic              pop;
    logic [AWIDTH:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [AWIDTH-1:0] head_pc;
    logic              head_taken;
    logic [DWIDTH:0]   ctr_inc;
    logic [DWIDTH:0]   ctr_dec;
    logic [DWIDTH-1:0] new_ctr;

    bp_update_ctrl_cp4_upd_fifo #(
        .WIDTH (AWIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (upd.valid),
        .pop_i   (pop),
        .din_i   ({upd.pc, upd.taken}),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_pc    = fifo_head[AWIDTH:1];
    assign head_taken = fifo_head[0];
    assign upd.ready  = !fifo_full;
    assign cache_ra_o = head_pc;

    // One extra bit so that saturation is a compare, never a wrap.
    assign ctr_inc = {1'b0, cache_dout_i} + 1'b1;
    assign ctr_dec = {1'b0, cache_dout_i} - 1'b1;

    always_comb begin
        new_ctr = '0;
        if (!cache_hit_i) begin
            new_ctr = head_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        end else if (head_taken) begin
            new_ctr = (ctr_inc > CTR_MAX) ? CTR_MAX[DWIDTH-1:0] : ctr_inc[DWIDTH-1:0];
        end else begin
            new_ctr = ctr_dec[DWIDTH] ? '0 : ctr_dec[DWIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        din_d   = din_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                pop     = 1'b1;
                wa_d    = head_pc;
                din_d   = new_ctr;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = fifo_empty ? ST_IDLE : ST_LOOKUP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wa_q    <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            din_q   <= din_d;
        end
    end

    // Gate with reset so an in-flight write is dropped on the reset edge itself.
    assign cache_we_o  = (state_q == ST_WRITE) && !reset;
    assign cache_wa_o  = wa_q;
    assign cache_din_o = din_q;
    assign pending_o   = fifo_count + CW'(state_q == ST_WRITE);
    assign idle_o      = fifo_empty && (state_q == ST_IDLE);
endmodule

// File: tb/tb_bp_update_ctrl_cp4.sv
// Directed bench for bp_update_ctrl_cp4 against a behavioural 8-line direct-mapped counter cache.
module tb_bp_update_ctrl_cp4;
    import bp_update_ctrl_cp4_pkg::*;

    localparam int AW = 30;
    localparam int DW = 2;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_update_ctrl_cp4_if #(.AWIDTH(AW)) upd_if();

    logic [AW-1:0] cache_ra, cache_wa;
    logic [DW-1:0] cache_dout, cache_din;
    logic          cache_hit, cache_we;
    logic [CW-1:0] pending;
    logic          idle;

    bp_update_ctrl_cp4 #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .upd          (upd_if),
        .cache_ra_o   (cache_ra),
        .cache_dout_i (cache_dout),
        .cache_hit_i  (cache_hit),
        .cache_wa_o   (cache_wa),
        .cache_din_o  (cache_din),
        .cache_we_o   (cache_we),
        .pending_o    (pending),
        .idle_o       (idle)
    );

    // Counter cache: 8 lines, index pc[2:0], tag pc[29:3].
    logic          c_vld [8];
    logic [AW-4:0] c_tag [8];
    logic [DW-1:0] c_ctr [8];

    assign cache_hit  = c_vld[cache_ra[2:0]] && (c_tag[cache_ra[2:0]] == cache_ra[AW-1:3]);
    assign cache_dout = c_ctr[cache_ra[2:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) c_vld[i] <= 1'b0;
        end else if (cache_we) begin
            c_vld[cache_wa[2:0]] <= 1'b1;
            c_tag[cache_wa[2:0]] <= cache_wa[AW-1:3];
            c_ctr[cache_wa[2:0]] <= cache_din;
        end
    end

    function automatic logic p0_hit(input logic [AW-1:0] pc);
        return c_vld[pc[2:0]] && (c_tag[pc[2:0]] == pc[AW-1:3]);
    endfunction

    function automatic logic [DW-1:0] p0_dout(input logic [AW-1:0] pc);
        return c_ctr[pc[2:0]];
    endfunction

    // Write log: every committed cache write with the cycle it happened in.
    int            cyc;
    logic [AW-1:0] wl_pc  [$];
    logic [DW-1:0] wl_din [$];
    int            wl_cyc [$];

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            if (cache_we === 1'b1) begin
                wl_pc.push_back(cache_wa);
                wl_din.push_back(cache_din);
                wl_cyc.push_back(cyc);
            end
            cyc++;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        upd_if.valid = 1'b0;
        upd_if.pc    = '0;
        upd_if.taken = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        wl_pc.delete();
        wl_din.delete();
        wl_cyc.delete();
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic t);
        int n;
        n = 0;
        upd_if.valid = 1'b1;
        upd_if.pc    = pc;
        upd_if.taken = t;
        while (!upd_if.ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("push_timeout", 32'd0, 32'd1);
        tick();
        upd_if.valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!idle && n < 60) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    logic [DW-1:0] exp2   [8] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    logic [AW-1:0] exp4pc [7] = '{30'h100, 30'h101, 30'h102, 30'h103, 30'h104, 30'h105, 30'h107};
    logic [DW-1:0] exp4d  [7] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, single miss, cycle-accurate sequencing
        do_reset();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(upd_if.ready), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_we", 32'(cache_we), 32'd0);
        chk("rst_wa", 32'(cache_wa), 32'd0);
        chk("rst_din", 32'(cache_din), 32'd0);
        push(30'h10, 1'b1);
        chk("t1_q_pending", 32'(pending), 32'd1);
        chk("t1_q_idle", 32'(idle), 32'd0);
        chk("t1_q_we", 32'(cache_we), 32'd0);
        tick();
        chk("t1_lk_ra", 32'(cache_ra), 32'h10);
        chk("t1_lk_we", 32'(cache_we), 32'd0);
        chk("t1_lk_pending", 32'(pending), 32'd1);
        tick();
        chk("t1_wr_we", 32'(cache_we), 32'd1);
        chk("t1_wr_wa", 32'(cache_wa), 32'h10);
        chk("t1_wr_din", 32'(cache_din), 32'd2);
        chk("t1_wr_pending", 32'(pending), 32'd1);
        tick();
        chk("t1_done_we", 32'(cache_we), 32'd0);
        chk("t1_done_pending", 32'(pending), 32'd0);
        chk("t1_done_idle", 32'(idle), 32'd1);
        chk("t1_nwrites", 32'(wl_pc.size()), 32'd1);
        chk("t1_p0_hit", 32'(p0_hit(30'h10)), 32'd1);
        chk("t1_p0_dout", 32'(p0_dout(30'h10)), 32'd2);

        // 2: saturation up and down on one line
        do_reset();
        for (int i = 0; i < 4; i++) push(30'h10, 1'b1);
        for (int i = 0; i < 4; i++) push(30'h10, 1'b0);
        wait_idle();
        chk("t2_nwrites", 32'(wl_pc.size()), 32'd8);
        for (int i = 0; i < 8 && i < wl_pc.size(); i++) begin
            chk($sformatf("t2_wa%0d", i), 32'(wl_pc[i]), 32'h10);
            chk($sformatf("t2_din%0d", i), 32'(wl_din[i]), 32'(exp2[i]));
        end

        // 3: alias on index 0 with a different tag
        do_reset();
        push(30'h10, 1'b1);
        push(30'h18, 1'b0);
        wait_idle();
        chk("t3_nwrites", 32'(wl_pc.size()), 32'd2);
        if (wl_pc.size() == 2) begin
            chk("t3_wa0", 32'(wl_pc[0]), 32'h10);
            chk("t3_din0", 32'(wl_din[0]), 32'd2);
            chk("t3_wa1", 32'(wl_pc[1]), 32'h18);
            chk("t3_din1", 32'(wl_din[1]), 32'd1);
        end
        chk("t3_p0_hit10", 32'(p0_hit(30'h10)), 32'd0);
        chk("t3_p0_hit18", 32'(p0_hit(30'h18)), 32'd1);
        chk("t3_p0_dout18", 32'(p0_dout(30'h18)), 32'd1);

        // 4 + 6: valid held 8 cycles, queue fills, push into WRITE at full-1
        do_reset();
        for (int i = 0; i < 8; i++) begin
            upd_if.valid = 1'b1;
            upd_if.pc    = AW'(32'h100 + i);
            upd_if.taken = i[0];
            if (i == 5) begin
                chk("t6_write_we", 32'(cache_we), 32'd1);
                chk("t6_write_ready", 32'(upd_if.ready), 32'd1);
                chk("t6_write_pending", 32'(pending), 32'd4);
            end
            if (i == 6) begin
                chk("t4_full_ready", 32'(upd_if.ready), 32'd0);
                chk("t4_full_pending", 32'(pending), 32'd4);
            end
            tick();
        end
        upd_if.valid = 1'b0;
        wait_idle();
        chk("t4_nwrites", 32'(wl_pc.size()), 32'd7);
        for (int i = 0; i < 7 && i < wl_pc.size(); i++) begin
            chk($sformatf("t4_wa%0d", i), 32'(wl_pc[i]), 32'(exp4pc[i]));
            chk($sformatf("t4_din%0d", i), 32'(wl_din[i]), 32'(exp4d[i]));
            if (i > 0) chk($sformatf("t4_gap%0d", i), 32'(wl_cyc[i] - wl_cyc[i-1]), 32'd2);
        end

        // 5: reset during WRITE with three entries queued
        do_reset();
        for (int i = 0; i < 5; i++) push(AW'(32'h200 + i), 1'b1);
        chk("t5_pre_we", 32'(cache_we), 32'd1);
        chk("t5_pre_wa", 32'(cache_wa), 32'h201);
        chk("t5_pre_pending", 32'(pending), 32'd4);
        reset = 1'b1;
        #1;
        chk("t5_we_gated", 32'(cache_we), 32'd0);
        tick();
        reset = 1'b0;
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        chk("t5_ready", 32'(upd_if.ready), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_nwrites", 32'(wl_pc.size()), 32'd1);
        if (wl_pc.size() > 0) chk("t5_wa0", 32'(wl_pc[0]), 32'h200);
        chk("t5_idle_after", 32'(idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
